// File: rtl/seven_segments_frame_encoder.sv
// seven_segments_frame_encoder
//   Turns a frame of active-low seven-segment characters into a DW-bit
//   two's-complement number. The most-significant digit arrives first.
//   This is the inverse of the binary-to-seven-segment display path.
//   Leading blanks are skipped. An optional leading minus is allowed,
//   followed by up to MAX_DIGITS decimal digits. Any malformed frame
//   gives out_error=1 with binary_number=0.
//
// Ports
//   clk            clock
//   rst_n          asynchronous active-low reset
//   seg_pattern    one character pattern (bit 6 = g ... bit 0 = a), active-low
//   in_valid       seg_pattern / in_last valid
//   in_last        final character of the frame
//   in_ready       block accepts a character (low in DONE and in reset)
//   binary_number  two's-complement result, held while out_valid=1
//   out_error      frame rejected; binary_number is 0
//   out_valid      result valid
//   out_ready      consumer accepts the result
module seven_segments_frame_encoder #(
  parameter int DW         = 8,
  parameter int SEGMENTS   = 7,
  parameter int MAX_DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SEGMENTS-1:0] seg_pattern,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic [DW-1:0]       binary_number,
  output logic                out_error,
  output logic                out_valid,
  input  logic                out_ready
);

  // The magnitude holds up to 10^MAX_DIGITS - 1, so the digit path never truncates.
  localparam int ACC_W = $clog2(10 ** MAX_DIGITS);
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [31:0] POS_LIMIT = 32'((2 ** (DW - 1)) - 1);
  localparam logic [31:0] NEG_LIMIT = 32'(2 ** (DW - 1));

  typedef enum logic {COLLECT, DONE} state_t;
  typedef enum logic [1:0] {CH_DIGIT, CH_MINUS, CH_BLANK, CH_INVALID} char_kind_t;

  state_t           state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             neg_reg, neg_next;
  logic             err_reg, err_next;
  logic             seen_reg, seen_next;
  logic [DW-1:0]    num_reg, num_next;
  logic             oerr_reg, oerr_next;

  char_kind_t       char_kind;
  logic [3:0]       char_digit;
  logic             collect_ready;
  logic             final_err;
  logic [31:0]      acc_wide;
  logic [31:0]      signed_wide;
  logic [ACC_W-1:0] acc_x10;

  // Character decoder.
  always_comb begin
    char_kind  = CH_INVALID;
    char_digit = 4'd0;
    case (seg_pattern)
      7'b1000000: begin char_kind = CH_DIGIT; char_digit = 4'd0; end
      7'b1111001: begin char_kind = CH_DIGIT; char_digit = 4'd1; end
      7'b0100100: begin char_kind = CH_DIGIT; char_digit = 4'd2; end
      7'b0110000: begin char_kind = CH_DIGIT; char_digit = 4'd3; end
      7'b0011001: begin char_kind = CH_DIGIT; char_digit = 4'd4; end
      7'b0010010: begin char_kind = CH_DIGIT; char_digit = 4'd5; end
      7'b0000010: begin char_kind = CH_DIGIT; char_digit = 4'd6; end
      7'b1111000: begin char_kind = CH_DIGIT; char_digit = 4'd7; end
      7'b0000000: begin char_kind = CH_DIGIT; char_digit = 4'd8; end
      7'b0010000: begin char_kind = CH_DIGIT; char_digit = 4'd9; end
      7'b0111111: char_kind = CH_MINUS;
      7'b1111111: char_kind = CH_BLANK;
      default:    char_kind = CH_INVALID;
    endcase
  end

  // Multiply by 10 with shifts. It is only applied while cnt < MAX_DIGITS,
  // so the result plus one more digit still fits in ACC_W bits.
  assign acc_x10 = (acc_reg << 3) + (acc_reg << 1);

  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    cnt_next      = cnt_reg;
    neg_next      = neg_reg;
    err_next      = err_reg;
    seen_next     = seen_reg;
    num_next      = num_reg;
    oerr_next     = oerr_reg;
    collect_ready = 1'b0;
    out_valid     = 1'b0;
    final_err     = 1'b0;
    acc_wide      = 32'd0;
    signed_wide   = 32'd0;
    case (state_reg)
      COLLECT: begin
        collect_ready = 1'b1;
        if (in_valid) begin
          case (char_kind)
            CH_BLANK: begin
              // A blank after any real character breaks the number.
              if (seen_reg) err_next = 1'b1;
            end
            CH_MINUS: begin
              if (seen_reg) begin
                err_next = 1'b1;
              end else begin
                neg_next  = 1'b1;
                seen_next = 1'b1;
              end
            end
            CH_DIGIT: begin
              seen_next = 1'b1;
              if (cnt_reg == CNT_W'(MAX_DIGITS)) begin
                err_next = 1'b1;
              end else begin
                acc_next = acc_x10 + ACC_W'(char_digit);
                cnt_next = cnt_reg + 1'b1;
              end
            end
            default: err_next = 1'b1;
          endcase
          // The result is formed from this beat's updated values.
          if (in_last) begin
            acc_wide    = 32'(acc_next);
            final_err   = err_next || (cnt_next == '0) ||
                          (!neg_next && (acc_wide > POS_LIMIT)) ||
                          ( neg_next && (acc_wide > NEG_LIMIT));
            signed_wide = neg_next ? (32'd0 - acc_wide) : acc_wide;
            num_next    = final_err ? '0 : signed_wide[DW-1:0];
            oerr_next   = final_err;
            state_next  = DONE;
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = COLLECT;
          acc_next   = '0;
          cnt_next   = '0;
          neg_next   = 1'b0;
          err_next   = 1'b0;
          seen_next  = 1'b0;
          num_next   = '0;
          oerr_next  = 1'b0;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= COLLECT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg  <= '0;
      cnt_reg  <= '0;
      neg_reg  <= 1'b0;
      err_reg  <= 1'b0;
      seen_reg <= 1'b0;
      num_reg  <= '0;
      oerr_reg <= 1'b0;
    end else begin
      acc_reg  <= acc_next;
      cnt_reg  <= cnt_next;
      neg_reg  <= neg_next;
      err_reg  <= err_next;
      seen_reg <= seen_next;
      num_reg  <= num_next;
      oerr_reg <= oerr_next;
    end
  end

  // in_ready is gated by rst_n so it drops at once when reset is asserted.
  assign in_ready      = collect_ready & rst_n;
  assign binary_number = num_reg;
  assign out_error     = oerr_reg;

endmodule

// File: tb/tb_seven_segments_frame_encoder.sv
// Directed bench for seven_segments_frame_encoder with a result scoreboard.
module tb_seven_segments_frame_encoder;

  localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100,
                         D3 = 7'b0110000, D4 = 7'b0011001, D5 = 7'b0010010,
                         D6 = 7'b0000010, D7 = 7'b1111000, D8 = 7'b0000000,
                         D9 = 7'b0010000, MINUS = 7'b0111111, BLANK = 7'b1111111,
                         CH_A = 7'b0001000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg_pattern;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] binary_number;
  logic       out_error;
  logic       out_valid;
  logic       out_ready;

  int total = 0;
  int bad   = 0;
  int beats = 0;

  logic [8:0] sb_q[$];   // {error, value}
  logic [6:0] fr[$];
  logic [8:0] sb_e;

  seven_segments_frame_encoder #(.DW(8), .SEGMENTS(7), .MAX_DIGITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .seg_pattern(seg_pattern), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .binary_number(binary_number),
    .out_error(out_error), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Monitor: counts accepted beats and scores every delivered result.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (in_valid && in_ready) beats++;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_result", {23'd0, out_error, binary_number}, 32'h1ff);
        end else begin
          sb_e = sb_q.pop_front();
          check("sb_value", 32'(binary_number), 32'(sb_e[7:0]));
          check("sb_error", 32'(out_error), 32'(sb_e[8]));
          $display("result value=%02h error=%0b (expected %02h/%0b)",
                   binary_number, out_error, sb_e[7:0], sb_e[8]);
        end
      end
    end
  end

  task automatic send_char(input logic [6:0] p, input logic last);
    bit ok;
    ok = 1'b0;
    seg_pattern = p;
    in_last     = last;
    in_valid    = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Sends fr as one frame and leaves the bench at the negedge after the last beat
  // (or after the handshake when out_ready is high).
  task automatic send_frame(input logic eerr, input logic [7:0] evalue);
    int n;
    int start;
    n     = fr.size();
    start = beats;
    sb_q.push_back({eerr, evalue});
    for (int i = 0; i < n; i++) send_char(fr[i], (i == n - 1));
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("beats_consumed", 32'(beats - start), 32'(n));
    @(negedge clk);
    check("out_valid_latency", 32'(out_valid), 32'd1);
    fr.delete();
    if (out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    seg_pattern = BLANK;
    out_ready   = 1'b1;

    // Reset state
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_binary", 32'(binary_number), 32'd0);
    check("rst_out_error", 32'(out_error), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Range boundaries
    fr = '{MINUS, D1, D2, D8};  send_frame(1'b0, 8'h80);
    fr = '{D1, D2, D7};         send_frame(1'b0, 8'h7F);
    fr = '{D1, D2, D8};         send_frame(1'b1, 8'h00);
    fr = '{MINUS, D1, D2, D9};  send_frame(1'b1, 8'h00);

    // Blanks, minus placement, invalid characters
    fr = '{BLANK, BLANK, D5};   send_frame(1'b0, 8'h05);
    fr = '{D4, BLANK, D2};      send_frame(1'b1, 8'h00);
    fr = '{D7, MINUS};          send_frame(1'b1, 8'h00);
    fr = '{CH_A, D3};           send_frame(1'b1, 8'h00);
    fr = '{MINUS};              send_frame(1'b1, 8'h00);
    fr = '{MINUS, D0};          send_frame(1'b0, 8'h00);

    // Too many digits: every beat is still consumed
    fr = '{D1, D2, D3, D4};     send_frame(1'b1, 8'h00);
    fr = '{D4, D2};             send_frame(1'b0, 8'h2A);

    // Backpressure: the result and in_ready=0 hold while out_ready is low
    out_ready = 1'b0;
    fr = '{D9, D9};             send_frame(1'b0, 8'h63);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_binary", 32'(binary_number), 32'h63);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_in_ready_after", 32'(in_ready), 32'd1);
    check("bp_out_valid_after", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    fr = '{D3};                 send_frame(1'b0, 8'h03);

    // Reset in the middle of a frame discards it
    send_char(MINUS, 1'b0);
    send_char(D4, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_binary", 32'(binary_number), 32'd0);
    check("midrst_out_error", 32'(out_error), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    fr = '{D6};                 send_frame(1'b0, 8'h06);

    // Every expected result must have been delivered
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
